// File: rtl/stage4.sv
// Memory-access pipeline stage: multi-cycle data-memory loads/stores with an upstream
// stall, plus the MEM/WB pipeline register feeding write-back and forwarding.
module stage4 #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Ex_Mem_aluResult,
  input  logic [7:0] Ex_Mem_storeData,
  input  logic       Ex_Mem_memRead,
  input  logic       Ex_Mem_memWrite,
  input  logic       Ex_Mem_memToReg,
  input  logic       Ex_Mem_regWrite,
  input  logic [2:0] Ex_Mem_destReg,
  output logic       memStall,
  output logic [7:0] Mem_Wb_aluResult,
  output logic [2:0] Mem_Wb_destReg,
  output logic       Mem_Wb_regWrite,
  output logic       dbg_busy
);
  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam bit         MULTI    = (WAIT_CYCLES > 1);
  localparam logic [2:0] CNT_INIT = 3'(WAIT_CYCLES > 1 ? WAIT_CYCLES - 2 : 0);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [7:0]           alu_q, sdata_q;
  logic                 rd_q, wr_q, m2r_q, rw_q;
  logic [2:0]           dest_q;
  logic                 latch_en;
  logic [7:0]           mem_q [DEPTH];
  logic                 mem_we;
  logic [7:0]           wb_val_q, wb_val_d;
  logic [2:0]           wb_dest_q, wb_dest_d;
  logic                 wb_rw_q, wb_rw_d;

  logic                 req, busy, do_complete;
  logic [7:0]           f_alu, f_sdata, mem_rdata, acc_val;
  logic                 f_rd, f_wr, f_m2r, f_rw;
  logic [2:0]           f_dest;
  logic [ADDR_BITS-1:0] f_addr;

  assign req  = Ex_Mem_memRead | Ex_Mem_memWrite;
  assign busy = (state_q == S_BUSY);

  // While busy only the latched request is used; live inputs are ignored.
  assign f_alu     = busy ? alu_q   : Ex_Mem_aluResult;
  assign f_sdata   = busy ? sdata_q : Ex_Mem_storeData;
  assign f_rd      = busy ? rd_q    : Ex_Mem_memRead;
  assign f_wr      = busy ? wr_q    : Ex_Mem_memWrite;
  assign f_m2r     = busy ? m2r_q   : Ex_Mem_memToReg;
  assign f_rw      = busy ? rw_q    : Ex_Mem_regWrite;
  assign f_dest    = busy ? dest_q  : Ex_Mem_destReg;
  assign f_addr    = f_alu[ADDR_BITS-1:0];
  assign mem_rdata = mem_q[f_addr];
  // A combined read+write is treated as a store, so it writes back the ALU result.
  assign acc_val   = (f_m2r && !(f_rd && f_wr)) ? mem_rdata : f_alu;

  // Stall depends only on state, counter and request; reset forces it low at once.
  assign memStall = !rst && (busy ? (cnt_q != 3'd0) : (req && MULTI));
  assign dbg_busy = busy;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    latch_en    = 1'b0;
    do_complete = 1'b0;
    wb_val_d    = wb_val_q;
    wb_dest_d   = wb_dest_q;
    wb_rw_d     = wb_rw_q;
    unique case (state_q)
      S_IDLE: begin
        if (!req) begin
          wb_val_d  = Ex_Mem_aluResult;
          wb_dest_d = Ex_Mem_destReg;
          wb_rw_d   = Ex_Mem_regWrite;
        end else if (!MULTI) begin
          do_complete = 1'b1;
        end else begin
          latch_en = 1'b1;
          cnt_d    = CNT_INIT;
          state_d  = S_BUSY;
          wb_rw_d  = 1'b0;
        end
      end
      S_BUSY: begin
        if (cnt_q != 3'd0) begin
          cnt_d   = cnt_q - 3'd1;
          wb_rw_d = 1'b0;
        end else begin
          do_complete = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (do_complete) begin
      wb_val_d  = acc_val;
      wb_dest_d = f_dest;
      wb_rw_d   = f_rw;
    end
  end

  assign mem_we = do_complete && f_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      wb_val_q  <= 8'd0;
      wb_dest_q <= 3'd0;
      wb_rw_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wb_val_q  <= wb_val_d;
      wb_dest_q <= wb_dest_d;
      wb_rw_q   <= wb_rw_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_q   <= 8'd0;
      sdata_q <= 8'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      m2r_q   <= 1'b0;
      rw_q    <= 1'b0;
      dest_q  <= 3'd0;
    end else if (latch_en) begin
      alu_q   <= Ex_Mem_aluResult;
      sdata_q <= Ex_Mem_storeData;
      rd_q    <= Ex_Mem_memRead;
      wr_q    <= Ex_Mem_memWrite;
      m2r_q   <= Ex_Mem_memToReg;
      rw_q    <= Ex_Mem_regWrite;
      dest_q  <= Ex_Mem_destReg;
    end
  end

  // Reset clears every byte, so an aborted store can never land.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'd0;
    end else if (mem_we) begin
      mem_q[f_addr] <= f_sdata;
    end
  end

  assign Mem_Wb_aluResult = wb_val_q;
  assign Mem_Wb_destReg   = wb_dest_q;
  assign Mem_Wb_regWrite  = wb_rw_q;
endmodule

// File: tb/tb_stage4.sv
// Bench for stage4: three instances (WAIT_CYCLES 1, 2, 4) driven by a vector table,
// hand sequences for stall/abort corners, and random traffic against a byte-array model.
module tb_stage4;
  logic       clk;
  logic       rst;
  logic [7:0] alu [3];
  logic [7:0] sd  [3];
  logic       rd  [3];
  logic       wr  [3];
  logic       m2r [3];
  logic       rw  [3];
  logic [2:0] dst [3];
  logic       stall [3];
  logic [7:0] wbv [3];
  logic [2:0] wbd [3];
  logic       wbr [3];
  logic       dbg [3];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mdl [3][256];

  typedef struct {
    int         k;
    logic [7:0] a;
    logic [7:0] s;
    logic       r;
    logic       w;
    logic       m;
    logic       rwi;
    logic [2:0] d;
    logic [7:0] ev;
    logic       erw;
    logic [2:0] ed;
  } vec_t;
  vec_t tbl [14];

  stage4 #(.ADDR_BITS(8), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .Ex_Mem_aluResult(alu[0]), .Ex_Mem_storeData(sd[0]),
    .Ex_Mem_memRead(rd[0]), .Ex_Mem_memWrite(wr[0]), .Ex_Mem_memToReg(m2r[0]),
    .Ex_Mem_regWrite(rw[0]), .Ex_Mem_destReg(dst[0]), .memStall(stall[0]),
    .Mem_Wb_aluResult(wbv[0]), .Mem_Wb_destReg(wbd[0]), .Mem_Wb_regWrite(wbr[0]),
    .dbg_busy(dbg[0]));
  stage4 #(.ADDR_BITS(8), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst), .Ex_Mem_aluResult(alu[1]), .Ex_Mem_storeData(sd[1]),
    .Ex_Mem_memRead(rd[1]), .Ex_Mem_memWrite(wr[1]), .Ex_Mem_memToReg(m2r[1]),
    .Ex_Mem_regWrite(rw[1]), .Ex_Mem_destReg(dst[1]), .memStall(stall[1]),
    .Mem_Wb_aluResult(wbv[1]), .Mem_Wb_destReg(wbd[1]), .Mem_Wb_regWrite(wbr[1]),
    .dbg_busy(dbg[1]));
  stage4 #(.ADDR_BITS(8), .WAIT_CYCLES(4)) u_w4 (
    .clk(clk), .rst(rst), .Ex_Mem_aluResult(alu[2]), .Ex_Mem_storeData(sd[2]),
    .Ex_Mem_memRead(rd[2]), .Ex_Mem_memWrite(wr[2]), .Ex_Mem_memToReg(m2r[2]),
    .Ex_Mem_regWrite(rw[2]), .Ex_Mem_destReg(dst[2]), .memStall(stall[2]),
    .Mem_Wb_aluResult(wbv[2]), .Mem_Wb_destReg(wbd[2]), .Mem_Wb_regWrite(wbr[2]),
    .dbg_busy(dbg[2]));

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int wc(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_idle(input int k);
    alu[k] = 8'd0; sd[k] = 8'd0; rd[k] = 1'b0; wr[k] = 1'b0;
    m2r[k] = 1'b0; rw[k] = 1'b0; dst[k] = 3'd0;
  endtask

  // Driver: called just after a rising edge; returns just after the completing edge.
  task automatic exec(input int k, input logic [7:0] a, input logic [7:0] s,
                      input logic r, input logic w, input logic m, input logic rwi,
                      input logic [2:0] d, input logic [7:0] ev, input logic erw,
                      input logic [2:0] ed, input string nm);
    int stalls;
    bit done;
    logic st;
    alu[k] = a; sd[k] = s; rd[k] = r; wr[k] = w; m2r[k] = m; rw[k] = rwi; dst[k] = d;
    stalls = 0;
    done = 1'b0;
    for (int c = 0; c < 16 && !done; c++) begin
      @(negedge clk);
      st = stall[k];
      @(posedge clk);
      #1;
      if (st) begin
        stalls++;
        chk({nm, " bubble"}, 32'(wbr[k]), 32'd0);
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: got stall still high expected completion", nm);
    end
    chk({nm, " stalls"}, 32'(stalls), 32'((r | w) ? wc(k) - 1 : 0));
    chk({nm, " value"}, 32'(wbv[k]), 32'(ev));
    chk({nm, " regwr"}, 32'(wbr[k]), 32'(erw));
    chk({nm, " dest"}, 32'(wbd[k]), 32'(ed));
    set_idle(k);
  endtask

  initial begin
    int t0;
    logic [7:0] a, s, ev;
    logic m, rwi;
    logic [2:0] d;
    int k, op;

    rst = 1'b0;
    for (int i = 0; i < 3; i++) set_idle(i);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d stall", i), 32'(stall[i]), 32'd0);
      chk($sformatf("rst%0d value", i), 32'(wbv[i]), 32'd0);
      chk($sformatf("rst%0d dest", i), 32'(wbd[i]), 32'd0);
      chk($sformatf("rst%0d regwr", i), 32'(wbr[i]), 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    //           k  alu    sd     rd  wr  m2r rw  dest    exp    erw  edest
    tbl[0]  = '{1, 8'h5A, 8'h00, 0, 0, 0, 1, 3'd3, 8'h5A, 1, 3'd3};
    tbl[1]  = '{1, 8'h20, 8'hA5, 0, 1, 0, 0, 3'd0, 8'h20, 0, 3'd0};
    tbl[2]  = '{1, 8'h20, 8'h00, 1, 0, 1, 1, 3'd5, 8'hA5, 1, 3'd5};
    tbl[3]  = '{1, 8'h10, 8'hC3, 0, 1, 0, 1, 3'd4, 8'h10, 1, 3'd4};
    tbl[4]  = '{1, 8'h10, 8'h00, 1, 0, 0, 1, 3'd6, 8'h10, 1, 3'd6};
    tbl[5]  = '{1, 8'h50, 8'h99, 1, 1, 1, 1, 3'd2, 8'h50, 1, 3'd2};
    tbl[6]  = '{1, 8'h50, 8'h00, 1, 0, 1, 1, 3'd7, 8'h99, 1, 3'd7};
    tbl[7]  = '{0, 8'h11, 8'h3C, 0, 1, 0, 0, 3'd1, 8'h11, 0, 3'd1};
    tbl[8]  = '{0, 8'h11, 8'h00, 1, 0, 1, 1, 3'd2, 8'h3C, 1, 3'd2};
    tbl[9]  = '{0, 8'h77, 8'h00, 0, 0, 1, 1, 3'd6, 8'h77, 1, 3'd6};
    tbl[10] = '{2, 8'h12, 8'h66, 0, 1, 0, 0, 3'd0, 8'h12, 0, 3'd0};
    tbl[11] = '{2, 8'h12, 8'h00, 1, 0, 1, 1, 3'd3, 8'h66, 1, 3'd3};
    tbl[12] = '{2, 8'hE1, 8'h00, 0, 0, 0, 0, 3'd5, 8'hE1, 0, 3'd5};
    tbl[13] = '{1, 8'h30, 8'h31, 0, 1, 0, 0, 3'd0, 8'h30, 0, 3'd0};
    for (int i = 0; i < 14; i++)
      exec(tbl[i].k, tbl[i].a, tbl[i].s, tbl[i].r, tbl[i].w, tbl[i].m, tbl[i].rwi,
           tbl[i].d, tbl[i].ev, tbl[i].erw, tbl[i].ed, $sformatf("tbl%0d", i));

    // Address changes during the stall cycle of a store must not redirect it.
    alu[1] = 8'h20; sd[1] = 8'h77; wr[1] = 1'b1;
    @(negedge clk);
    chk("chg stall", 32'(stall[1]), 32'd1);
    @(posedge clk);
    #1;
    chk("chg bubble", 32'(wbr[1]), 32'd0);
    alu[1] = 8'h30;
    sd[1]  = 8'hEE;
    @(negedge clk);
    chk("chg stall end", 32'(stall[1]), 32'd0);
    @(posedge clk);
    #1;
    chk("chg value", 32'(wbv[1]), 32'h20);
    set_idle(1);
    exec(1, 8'h20, 8'h00, 1, 0, 1, 1, 3'd1, 8'h77, 1, 3'd1, "chg ld20");
    exec(1, 8'h30, 8'h00, 1, 0, 1, 1, 3'd2, 8'h31, 1, 3'd2, "chg ld30");

    // Back-to-back loads: one per cycle at WAIT 1, one per four cycles at WAIT 4.
    t0 = cyc;
    for (int i = 0; i < 3; i++)
      exec(0, 8'h11, 8'h00, 1, 0, 1, 1, 3'(i), 8'h3C, 1, 3'(i), $sformatf("b2b1_%0d", i));
    chk("b2b1 cycles", 32'(cyc - t0), 32'd3);
    t0 = cyc;
    for (int i = 0; i < 3; i++)
      exec(2, 8'h12, 8'h00, 1, 0, 1, 1, 3'(i + 4), 8'h66, 1, 3'(i + 4), $sformatf("b2b4_%0d", i));
    chk("b2b4 cycles", 32'(cyc - t0), 32'd12);

    // Reset mid-run with a load request pending on the WAIT 2 instance.
    alu[1] = 8'h10; rd[1] = 1'b1; m2r[1] = 1'b1; rw[1] = 1'b1; dst[1] = 3'd3;
    rst = 1'b1;
    #1;
    chk("midrst stall", 32'(stall[1]), 32'd0);
    chk("midrst value", 32'(wbv[1]), 32'd0);
    chk("midrst dest", 32'(wbd[1]), 32'd0);
    chk("midrst regwr", 32'(wbr[1]), 32'd0);
    set_idle(1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    exec(1, 8'h10, 8'h00, 1, 0, 1, 1, 3'd3, 8'h00, 1, 3'd3, "midrst ld10");

    // Abort a WAIT 4 store in its second busy cycle.
    alu[2] = 8'h40; sd[2] = 8'hFF; wr[2] = 1'b1;
    @(posedge clk);
    #1;
    chk("abort busy1", 32'(stall[2]), 32'd1);
    @(posedge clk);
    #1;
    chk("abort busy2", 32'(stall[2]), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort stall", 32'(stall[2]), 32'd0);
    chk("abort state", 32'(dbg[2]), 32'd0);
    set_idle(2);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    exec(2, 8'h40, 8'h00, 1, 0, 1, 1, 3'd2, 8'h00, 1, 3'd2, "abort ld40");

    // Random traffic after a clean reset against a plain byte-array model.
    rst = 1'b1;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 256; j++) mdl[i][j] = 8'd0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    for (int it = 0; it < 150; it++) begin
      k   = it % 3;
      op  = int'($urandom_range(0, 3));
      a   = (op == 0) ? 8'($urandom) : (8'h80 | 8'($urandom_range(0, 7)));
      s   = 8'($urandom);
      m   = (op == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      rwi = 1'($urandom_range(0, 1));
      d   = 3'($urandom_range(0, 7));
      if (op >= 2)                 ev = a;
      else if (op == 1 && m)       ev = mdl[k][a];
      else                         ev = a;
      if (op >= 2) mdl[k][a] = s;
      exp_q.push_back(ev);
      exec(k, a, s, op[0], op[1], m, rwi, d, exp_q.pop_front(), rwi, d,
           $sformatf("rnd%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/stage4.md
# stage4

Memory-access stage of the 8-bit pipelined datapath, directly downstream of the execute stage. It consumes the EX/MEM pipeline fields: ALU result/address, store data, memory and write-back controls. It performs data-memory loads and stores with a fixed multi-cycle access latency, stalling upstream while an access is in flight. It owns the MEM/WB pipeline register whose result feeds write-back and the execute stage's forwarding input `Mem_Wb_aluResult`.

## Interface
- `ADDR_BITS`, default 8: data memory has 2^ADDR_BITS bytes; address is `Ex_Mem_aluResult[ADDR_BITS-1:0]`.
- `WAIT_CYCLES`, default 2: cycles a memory access occupies the stage; legal range 1..8.
- `clk`  in  1  — single clock, all state updates on rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `Ex_Mem_aluResult`  in  8  — ALU result; memory address for loads/stores.
- `Ex_Mem_storeData`  in  8  — store data (already forwarded upstream).
- `Ex_Mem_memRead`  in  1  — load request.
- `Ex_Mem_memWrite`  in  1  — store request.
- `Ex_Mem_memToReg`  in  1  — write-back value is load data (1) or ALU result (0).
- `Ex_Mem_regWrite`  in  1  — instruction writes the register file.
- `Ex_Mem_destReg`  in  3  — destination register index.
- `memStall`  out  1  — combinational; upstream stages and EX/MEM register hold while high.
- `Mem_Wb_aluResult`  out  8  — registered write-back value (load data or ALU result).
- `Mem_Wb_destReg`  out  3  — registered destination index.
- `Mem_Wb_regWrite`  out  1  — registered write enable; 0 for bubbles.

## Operation
- **FSM states**
  - IDLE, BUSY.
  - 3-bit down-counter `cnt`.
  - Latched request: address, store data, read/write, memToReg, regWrite, destReg.
- **Request definition:** `req = Ex_Mem_memRead | Ex_Mem_memWrite`.
- **IDLE, no req**
  - Pass-through; MEM/WB loads `Ex_Mem_aluResult`, `destReg`, `regWrite` at the edge.
  - `memStall=0`.
- **IDLE, req, WAIT_CYCLES==1**
  - Access completes this cycle; `memStall=0`.
  - Store writes memory at the edge; load data reaches MEM/WB at the same edge.
  - Stay in IDLE.
- **IDLE, req, WAIT_CYCLES>1**
  - `memStall=1`; latch all request fields.
  - `cnt <= WAIT_CYCLES-2`; go to BUSY.
  - MEM/WB loads a bubble: `regWrite=0`, other fields hold.
- **BUSY, cnt!=0**
  - `memStall=1`; `cnt` decrements; MEM/WB loads a bubble.
  - Inputs are ignored; only latched fields are used.
- **BUSY, cnt==0 (completion)**
  - `memStall=0`; access uses latched fields.
  - Store writes `mem[addr] <= storeData` at the edge.
  - Load reads `mem[addr]` combinationally into MEM/WB.
  - MEM/WB loads the latched `destReg`/`regWrite`; go to IDLE.
- **Write-back value:** `memToReg ? memData : aluResult`. For a store with memToReg=0, the value is the address.
- **Read and write both set:** write only; the write-back value is the ALU result regardless of memToReg.
- **Memory array:** asynchronous read, synchronous write, no byte lanes. Address wraps modulo 2^ADDR_BITS.
- **Store-then-load ordering:** a load following a store to the same address returns the stored value. The store completes at an earlier edge.

## Timing
- **Reset values:** state=IDLE, cnt=0, `memStall=0`, `Mem_Wb_aluResult=0`, `Mem_Wb_destReg=0`, `Mem_Wb_regWrite=0`, all memory bytes 0.
- **Reset mid-access:** asserting `rst` during BUSY aborts immediately.
  - `memStall` drops asynchronously.
  - A pending store is not performed.
- **Latency, non-memory instruction:** 1 cycle to MEM/WB.
- **Latency, memory instruction:** WAIT_CYCLES cycles to MEM/WB.
  - `memStall` high for exactly WAIT_CYCLES-1 consecutive cycles.
- **Throughput:** back-to-back memory requests have no idle gap. The cycle after completion may accept a new request in IDLE.
- **Stall path:** `memStall` is combinational from state, `cnt` and `req` only. It has no path from data inputs.

## Test plan
- **Reset:** assert `rst` mid-run, then release.
  - All outputs are 0 and `memStall=0`.
  - A load from 0x10 then returns 0x00.
- **Pass-through:** present aluResult=0x5A, regWrite=1, destReg=3, no mem op.
  - Next edge gives Mem_Wb_aluResult=0x5A, destReg=3, regWrite=1.
  - `memStall` never rises.
- **Store then load, WAIT_CYCLES=2:** store 0xA5 to 0x20, then load 0x20 with memToReg=1, destReg=5.
  - Each access shows `memStall=1` for 1 cycle and a bubble (regWrite=0).
  - The load ends with Mem_Wb_aluResult=0xA5, destReg=5, regWrite=1.
- **Input change during BUSY:** switch aluResult 0x20→0x30 in the stall cycle of a store of 0x77.
  - `mem[0x20]=0x77`; `mem[0x30]` is unchanged.
- **WAIT_CYCLES=1 and WAIT_CYCLES=4 back-to-back loads**
  - WAIT_CYCLES=1: one result per cycle, no stall.
  - WAIT_CYCLES=4: stall 3 cycles per load, results spaced 4 cycles apart.
- **Abort, WAIT_CYCLES=4:** assert `rst` in the second BUSY cycle of a store of 0xFF to 0x40.
  - `memStall` drops at once.
  - After release, a load from 0x40 returns 0x00.
